spi_to_nitta_assembler: RTL

Receive-side counterpart of the NITTA-to-SPI word splitter. It collects SPI_DATA_WIDTH-wide bytes from the SPI slave core, MSB-first, into one DATA_WIDTH+ATTR_WIDTH word, then presents that word to the NITTA processor side with a one-cycle completion pulse and a valid/ack hold. It sits between the SPI slave receive path and the NITTA SPI processing unit's input buffer.

---
 rtl/spi_to_nitta_assembler.sv | 90 +++++++++
 1 files changed

// File: rtl/spi_to_nitta_assembler.sv
// Collects SPI bytes MSB-first into one DATA_WIDTH+ATTR_WIDTH word for the NITTA side.
// Completion raises a one-cycle pulse, and the word is held valid until it is acknowledged.
module spi_to_nitta_assembler #(
    parameter int DATA_WIDTH     = 32,
    parameter int ATTR_WIDTH     = 0,
    parameter int SPI_DATA_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             spi_frame,
    input  logic                             spi_ready,
    input  logic [SPI_DATA_WIDTH-1:0]        from_spi,
    output logic [DATA_WIDTH+ATTR_WIDTH-1:0] to_nitta,
    output logic                             assembler_ready,
    output logic                             word_valid,
    input  logic                             word_ack,
    output logic                             overflow
);
    localparam int W     = DATA_WIDTH + ATTR_WIDTH;
    localparam int BYTES = W / SPI_DATA_WIDTH;
    localparam int SBW   = W - SPI_DATA_WIDTH;
    localparam int CW    = (BYTES > 2) ? $clog2(BYTES) : 1;

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SBW-1:0] sbuf_q, sbuf_d;
    logic [W-1:0]   word_q, word_d;
    logic           rdy_q;
    logic           pulse_q, pulse_d;
    logic           valid_q, valid_d;
    logic           ovf_q, ovf_d;
    logic           strobe, last;

    // rdy_q resets high so a level already present at reset release is not a byte.
    assign strobe = spi_ready & ~rdy_q & spi_frame;
    assign last   = (cnt_q == CW'(BYTES - 1));

    always_comb begin
        cnt_d   = cnt_q;
        sbuf_d  = sbuf_q;
        word_d  = word_q;
        pulse_d = 1'b0;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (word_ack && valid_q)
            valid_d = 1'b0;
        if (!spi_frame) begin
            cnt_d  = '0;
            sbuf_d = '0;
        end else if (strobe) begin
            if (last) begin
                word_d  = {sbuf_q, from_spi};
                cnt_d   = '0;
                sbuf_d  = '0;
                pulse_d = 1'b1;
                valid_d = 1'b1;
                // An ack in the completion cycle consumed the old word, so nothing is lost.
                if (valid_q && !word_ack)
                    ovf_d = 1'b1;
            end else begin
                sbuf_d = SBW'({sbuf_q, from_spi});
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            sbuf_q  <= '0;
            word_q  <= '0;
            rdy_q   <= 1'b1;
            pulse_q <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sbuf_q  <= sbuf_d;
            word_q  <= word_d;
            rdy_q   <= spi_ready;
            pulse_q <= pulse_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign to_nitta        = word_q;
    assign assembler_ready = pulse_q;
    assign word_valid      = valid_q;
    assign overflow        = ovf_q;
endmodule
